// File: rtl/pong_pkg.sv
// Shared state encoding and default geometry for the pong game core.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int DEF_H_ACTIVE      = 800;
  localparam int DEF_V_ACTIVE      = 600;
  localparam int DEF_COORD_W       = 11;
  localparam int DEF_SCORE_W       = 5;
  localparam int DEF_BAT_H_SMALL   = 64;
  localparam int DEF_BAT_H_LARGE   = 128;
  localparam int DEF_BAT_W         = 8;
  localparam int DEF_BAT_X1        = 16;
  localparam int DEF_BAT_X2        = 776;
  localparam int DEF_BALL_SIZE     = 8;
  localparam int DEF_BAT_STEP      = 4;
  localparam int DEF_BALL_STEP     = 2;
  localparam int DEF_BALL_STEP_MAX = 6;
  localparam int DEF_WIN_SCORE     = 11;
  localparam int DEF_SERVE_FRAMES  = 60;

endpackage

// File: rtl/pong_paddle.sv
// Saturating paddle position register, updated once per frame tick.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int BAT_STEP = DEF_BAT_STEP,
  parameter int Y_CENTRE = (DEF_V_ACTIVE - DEF_BAT_H_SMALL) / 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               up,
  input  logic               dn,
  input  logic               freeze,
  input  logic [COORD_W-1:0] bat_h,
  output logic [COORD_W-1:0] y
);

  localparam logic [COORD_W:0]   V_TOP = (COORD_W+1)'(V_ACTIVE);
  localparam logic [COORD_W:0]   STEP  = (COORD_W+1)'(BAT_STEP);
  localparam logic [COORD_W-1:0] Y_RST = COORD_W'(Y_CENTRE);

  logic [COORD_W-1:0] y_q, y_d;
  logic [COORD_W:0]   y_e, y_max, y_up, y_dn;

  // Next position: clamp after a paddle size change wins over movement, even when frozen
  always_comb begin
    y_e   = {1'b0, y_q};
    y_max = V_TOP - {1'b0, bat_h};
    y_up  = (y_e >= STEP) ? y_e - STEP : '0;
    y_dn  = ((y_e + STEP) > y_max) ? y_max : y_e + STEP;
    y_d   = y_q;
    if (tick) begin
      if (y_e > y_max)                y_d = y_max[COORD_W-1:0];
      else if (!freeze && up && !dn)  y_d = y_up[COORD_W-1:0];
      else if (!freeze && dn && !up)  y_d = y_dn[COORD_W-1:0];
    end
  end

  // Position register, recentred by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= Y_RST;
    else     y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: rtl/pong_engine.sv
// Pong game core: paddles, ball, scores and match FSM, stepped per video frame.
// Optional macro PONG_SPEEDUP_EN: ball step grows by one per paddle hit up to BALL_STEP_MAX.
module pong_engine
  import pong_pkg::*;
#(
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int COORD_W       = DEF_COORD_W,
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int BAT_H_SMALL   = DEF_BAT_H_SMALL,
  parameter int BAT_H_LARGE   = DEF_BAT_H_LARGE,
  parameter int BAT_W         = DEF_BAT_W,
  parameter int BAT_X1        = DEF_BAT_X1,
  parameter int BAT_X2        = DEF_BAT_X2,
  parameter int BALL_SIZE     = DEF_BALL_SIZE,
  parameter int BAT_STEP      = DEF_BAT_STEP,
  parameter int BALL_STEP     = DEF_BALL_STEP,
  parameter int BALL_STEP_MAX = DEF_BALL_STEP_MAX,
  parameter int WIN_SCORE     = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES  = DEF_SERVE_FRAMES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               bat_size,
  input  logic               p1_up,
  input  logic               p1_dn,
  input  logic               p2_up,
  input  logic               p2_dn,
  output logic [COORD_W-1:0] p1_y,
  output logic [COORD_W-1:0] p2_y,
  output logic [COORD_W-1:0] bx,
  output logic [COORD_W-1:0] by,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         state,
  output logic               winner
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [COORD_W-1:0]        BX_C   = COORD_W'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0]        BY_C   = COORD_W'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic signed [COORD_W:0]   X_HIT1 = (COORD_W+1)'(BAT_X1 + BAT_W);
  localparam logic signed [COORD_W:0]   X_HIT2 = (COORD_W+1)'(BAT_X2 - BALL_SIZE);
  localparam logic signed [COORD_W:0]   X_MAX  = (COORD_W+1)'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [COORD_W:0]   Y_MAX  = (COORD_W+1)'(V_ACTIVE - BALL_SIZE);
  localparam logic [COORD_W:0]          BALL_E = (COORD_W+1)'(BALL_SIZE);
  localparam logic [SCORE_W-1:0]        WIN_S  = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]          SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
  logic               dx_q, dx_d, dy_q, dy_d;   // 1 = right / down
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d, s1_inc, s2_inc;
  logic               winner_q, winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [COORD_W-1:0]        bat_h;
  logic                      freeze;
  logic signed [COORD_W:0]   stp, sbx, sby, nbx, nby;
  logic [COORD_W:0]          by_e, p1_e, p2_e, bat_e;
  logic                      ov1, ov2, hit1, hit2;

  assign bat_h  = bat_size ? COORD_W'(BAT_H_LARGE) : COORD_W'(BAT_H_SMALL);
  assign freeze = (state_q == ST_IDLE) || (state_q == ST_OVER);

  pong_paddle #(.COORD_W(COORD_W), .V_ACTIVE(V_ACTIVE), .BAT_STEP(BAT_STEP),
                .Y_CENTRE((V_ACTIVE - BAT_H_SMALL) / 2)) u_bat1 (
    .clk(clk), .rst(rst), .tick(frame_tick), .up(p1_up), .dn(p1_dn),
    .freeze(freeze), .bat_h(bat_h), .y(p1_y));

  pong_paddle #(.COORD_W(COORD_W), .V_ACTIVE(V_ACTIVE), .BAT_STEP(BAT_STEP),
                .Y_CENTRE((V_ACTIVE - BAT_H_SMALL) / 2)) u_bat2 (
    .clk(clk), .rst(rst), .tick(frame_tick), .up(p2_up), .dn(p2_dn),
    .freeze(freeze), .bat_h(bat_h), .y(p2_y));

`ifdef PONG_SPEEDUP_EN
  localparam logic [COORD_W-1:0] STEP_MIN = COORD_W'(BALL_STEP);
  localparam logic [COORD_W-1:0] STEP_TOP = COORD_W'(BALL_STEP_MAX);
  logic [COORD_W-1:0] step_q, step_d;

  // Speed restarts on every serve and rises one notch per paddle return
  always_comb begin
    step_d = step_q;
    if (frame_tick) begin
      if (state_q == ST_SERVE) step_d = STEP_MIN;
      else if ((state_q == ST_PLAY) && (hit1 || hit2) && (step_q < STEP_TOP))
        step_d = step_q + COORD_W'(1);
    end
  end

  // Ball step register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= STEP_MIN;
    else     step_q <= step_d;
  end

  assign stp = $signed({1'b0, step_q});
`else
  assign stp = (COORD_W+1)'(BALL_STEP);
`endif

  // Candidate ball position and paddle collision tests against pre-tick paddles
  always_comb begin
    sbx   = $signed({1'b0, bx_q});
    sby   = $signed({1'b0, by_q});
    nbx   = dx_q ? sbx + stp : sbx - stp;
    nby   = dy_q ? sby + stp : sby - stp;
    by_e  = {1'b0, by_q};
    p1_e  = {1'b0, p1_y};
    p2_e  = {1'b0, p2_y};
    bat_e = {1'b0, bat_h};
    ov1   = ((by_e + BALL_E) > p1_e) && (by_e < (p1_e + bat_e));
    ov2   = ((by_e + BALL_E) > p2_e) && (by_e < (p2_e + bat_e));
    hit1  = !dx_q && (sbx >= X_HIT1) && (nbx < X_HIT1) && ov1;
    hit2  =  dx_q && (sbx <= X_HIT2) && (nbx > X_HIT2) && ov2;
  end

  // Match FSM next state plus ball, score and winner updates
  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    s1_inc   = score1_q + SCORE_W'(1);
    s2_inc   = score2_q + SCORE_W'(1);
    if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SERVE;
            bx_d    = BX_C;
            by_d    = BY_C;
            cnt_d   = '0;
          end
        end
        ST_SERVE: begin
          bx_d = BX_C;
          by_d = BY_C;
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          // vertical and horizontal resolution are independent so corners work
          by_d = nby[COORD_W-1:0];
          if (nby[COORD_W]) begin
            by_d = '0;
            dy_d = 1'b1;
          end else if (nby > Y_MAX) begin
            by_d = Y_MAX[COORD_W-1:0];
            dy_d = 1'b0;
          end
          bx_d = nbx[COORD_W-1:0];
          if (hit1) begin
            bx_d = X_HIT1[COORD_W-1:0];
            dx_d = 1'b1;
          end else if (hit2) begin
            bx_d = X_HIT2[COORD_W-1:0];
            dx_d = 1'b0;
          end else if (nbx[COORD_W]) begin
            score2_d = s2_inc;
            dy_d     = dy_q;
            if (s2_inc == WIN_S) begin
              state_d  = ST_OVER;
              winner_d = 1'b1;
              bx_d     = bx_q;
              by_d     = by_q;
            end else begin
              state_d = ST_SERVE;
              bx_d    = BX_C;
              by_d    = BY_C;
              dx_d    = 1'b0;
            end
          end else if (nbx > X_MAX) begin
            score1_d = s1_inc;
            dy_d     = dy_q;
            if (s1_inc == WIN_S) begin
              state_d  = ST_OVER;
              winner_d = 1'b0;
              bx_d     = bx_q;
              by_d     = by_q;
            end else begin
              state_d = ST_SERVE;
              bx_d    = BX_C;
              by_d    = BY_C;
              dx_d    = 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (start) begin
            state_d  = ST_SERVE;
            score1_d = '0;
            score2_d = '0;
            dx_d     = 1'b1;
            bx_d     = BX_C;
            by_d     = BY_C;
            cnt_d    = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Game state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bx_q     <= BX_C;
      by_q     <= BY_C;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      score1_q <= '0;
      score2_q <= '0;
      winner_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bx     = bx_q;
  assign by     = by_q;
  assign score1 = score1_q;
  assign score2 = score2_q;
  assign state  = state_q;
  assign winner = winner_q;

endmodule

// File: tb/tb_pong_engine.sv
// Directed testbench for pong_engine (default build, speed-up disabled).
module tb_pong_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0, start = 1'b0, bat_size = 1'b0;
  logic        p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic [10:0] p1_y, p2_y, bx, by;
  logic [4:0]  score1, score2;
  logic [1:0]  state;
  logic        winner;

  int checks = 0;
  int errors = 0;

  pong_engine dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .bat_size(bat_size),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .p1_y(p1_y), .p2_y(p2_y), .bx(bx), .by(by),
    .score1(score1), .score2(score2), .state(state), .winner(winner));

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {start, bat_size, p1_up, p1_dn, p2_up, p2_dn, frame_tick} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    {start, bat_size, p1_up, p1_dn, p2_up, p2_dn} = '0;
    frame_tick = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({p1_y, p2_y} !== {11'd268, 11'd268}) begin errors++; $display("FAIL reset_paddles p1=%0d p2=%0d exp 268/268", p1_y, p2_y); end
    checks++; if ({bx, by} !== {11'd396, 11'd296}) begin errors++; $display("FAIL reset_ball bx=%0d by=%0d exp 396/296", bx, by); end
    checks++; if ({score1, score2, state, winner} !== {5'd0, 5'd0, 2'd0, 1'b0}) begin errors++; $display("FAIL reset_match s1=%0d s2=%0d st=%0d w=%0d exp 0/0/0/0", score1, score2, state, winner); end
    frame_tick = 1'b0;
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_serve();
    do_reset();
    start = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_without_tick state=%0d exp 0", state); end
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_to_serve state=%0d exp 1", state); end
    start = 1'b0;
    ticks(59);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL serve_hold state=%0d exp 1", state); end
    tick();
    checks++; if ({state, bx, by} !== {2'd2, 11'd396, 11'd296}) begin errors++; $display("FAIL serve_to_play st=%0d bx=%0d by=%0d exp 2/396/296", state, bx, by); end
    tick();
    checks++; if ({bx, by} !== {11'd398, 11'd298}) begin errors++; $display("FAIL first_move bx=%0d by=%0d exp 398/298", bx, by); end
  endtask

  task automatic test_paddle();
    do_reset();
    p1_up = 1'b1;
    tick();
    checks++; if (p1_y !== 11'd268) begin errors++; $display("FAIL idle_frozen p1=%0d exp 268", p1_y); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (p1_y !== 11'd264) begin errors++; $display("FAIL bat_up_step p1=%0d exp 264", p1_y); end
    ticks(66);
    checks++; if (p1_y !== 11'd0) begin errors++; $display("FAIL bat_reach_top p1=%0d exp 0", p1_y); end
    ticks(3);
    checks++; if (p1_y !== 11'd0) begin errors++; $display("FAIL bat_sat_top p1=%0d exp 0", p1_y); end
    p1_dn = 1'b1;
    tick();
    checks++; if (p1_y !== 11'd0) begin errors++; $display("FAIL bat_up_dn_both p1=%0d exp 0", p1_y); end
    p1_up = 1'b0;
    bat_size = 1'b1;
    ticks(118);
    checks++; if (p1_y !== 11'd472) begin errors++; $display("FAIL bat_reach_bottom_large p1=%0d exp 472", p1_y); end
    tick();
    checks++; if (p1_y !== 11'd472) begin errors++; $display("FAIL bat_sat_bottom_large p1=%0d exp 472", p1_y); end
    bat_size = 1'b0;
    ticks(16);
    checks++; if (p1_y !== 11'd536) begin errors++; $display("FAIL bat_sat_bottom_small p1=%0d exp 536", p1_y); end
    p1_dn = 1'b0;
    bat_size = 1'b1;
    tick();
    checks++; if ({p1_y, p2_y} !== {11'd472, 11'd268}) begin errors++; $display("FAIL bat_clamp_grow p1=%0d p2=%0d exp 472/268", p1_y, p2_y); end
    bat_size = 1'b0;
  endtask

  task automatic test_wall();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(60 + 148);
    checks++; if ({bx, by} !== {11'd692, 11'd592}) begin errors++; $display("FAIL wall_bottom_reach bx=%0d by=%0d exp 692/592", bx, by); end
    tick();
    checks++; if ({bx, by} !== {11'd694, 11'd592}) begin errors++; $display("FAIL wall_bottom_clamp bx=%0d by=%0d exp 694/592", bx, by); end
    tick();
    checks++; if ({bx, by} !== {11'd696, 11'd590}) begin errors++; $display("FAIL wall_bottom_bounce bx=%0d by=%0d exp 696/590", bx, by); end
    ticks(48);
    checks++; if ({state, bx, by} !== {2'd2, 11'd792, 11'd494}) begin errors++; $display("FAIL right_edge st=%0d bx=%0d by=%0d exp 2/792/494", state, bx, by); end
    tick();
    checks++; if ({score1, score2, state, bx, by} !== {5'd1, 5'd0, 2'd1, 11'd396, 11'd296}) begin errors++; $display("FAIL p1_point s1=%0d s2=%0d st=%0d bx=%0d by=%0d exp 1/0/1/396/296", score1, score2, state, bx, by); end
    ticks(60 + 148);
    checks++; if ({bx, by} !== {11'd692, 11'd0}) begin errors++; $display("FAIL wall_top_reach bx=%0d by=%0d exp 692/0", bx, by); end
    tick();
    checks++; if ({bx, by} !== {11'd694, 11'd0}) begin errors++; $display("FAIL wall_top_clamp bx=%0d by=%0d exp 694/0", bx, by); end
    tick();
    checks++; if ({bx, by} !== {11'd696, 11'd2}) begin errors++; $display("FAIL wall_top_bounce bx=%0d by=%0d exp 696/2", bx, by); end
  endtask

  task automatic test_bat_return(input bit miss);
    logic [10:0] exp_p1;
    int          p1_hold;
    exp_p1  = miss ? 11'd0 : 11'd200;
    p1_hold = miss ? 70 : 17;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 70; i++) begin
      p1_up = (i < p1_hold);
      p2_dn = (i < 47);
      tick();
    end
    p1_up = 1'b0;
    p2_dn = 1'b0;
    checks++; if ({p1_y, p2_y} !== {exp_p1, 11'd456}) begin errors++; $display("FAIL return_setup miss=%0d p1=%0d p2=%0d exp %0d/456", miss, p1_y, p2_y, exp_p1); end
    ticks(177);
    checks++; if ({bx, by} !== {11'd768, 11'd516}) begin errors++; $display("FAIL bat2_hit bx=%0d by=%0d exp 768/516", bx, by); end
    ticks(371);
    checks++; if ({bx, by} !== {11'd26, 11'd224}) begin errors++; $display("FAIL left_approach bx=%0d by=%0d exp 26/224", bx, by); end
    tick();
    checks++; if ({bx, by} !== {11'd24, 11'd226}) begin errors++; $display("FAIL left_at_face bx=%0d by=%0d exp 24/226", bx, by); end
    tick();
    checks++; if ({bx, by} !== {(miss ? 11'd22 : 11'd24), 11'd228}) begin errors++; $display("FAIL bat1_event miss=%0d bx=%0d by=%0d exp %0d/228", miss, bx, by, miss ? 22 : 24); end
    tick();
    checks++; if ({bx, by} !== {(miss ? 11'd20 : 11'd26), 11'd230}) begin errors++; $display("FAIL bat1_after miss=%0d bx=%0d by=%0d exp %0d/230", miss, bx, by, miss ? 20 : 26); end
    if (miss) begin
      ticks(10);
      checks++; if ({bx, by} !== {11'd0, 11'd250}) begin errors++; $display("FAIL left_edge bx=%0d by=%0d exp 0/250", bx, by); end
      tick();
      checks++; if ({score1, score2, state, bx, by} !== {5'd0, 5'd1, 2'd1, 11'd396, 11'd296}) begin errors++; $display("FAIL p2_point s1=%0d s2=%0d st=%0d bx=%0d by=%0d exp 0/1/1/396/296", score1, score2, state, bx, by); end
      ticks(61);
      checks++; if ({bx, by} !== {11'd394, 11'd298}) begin errors++; $display("FAIL serve_toward_loser bx=%0d by=%0d exp 394/298", bx, by); end
    end
  endtask

  task automatic test_win();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      ticks(259);
      checks++; if ({score1, state} !== {5'(r), 2'd1}) begin errors++; $display("FAIL round_%0d s1=%0d st=%0d exp %0d/1", r, score1, state, r); end
    end
    ticks(258);
    checks++; if ({state, bx, by} !== {2'd2, 11'd792, 11'd494}) begin errors++; $display("FAIL match_point st=%0d bx=%0d by=%0d exp 2/792/494", state, bx, by); end
    tick();
    checks++; if ({score1, score2, state, winner} !== {5'd11, 5'd0, 2'd3, 1'b0}) begin errors++; $display("FAIL game_over s1=%0d s2=%0d st=%0d w=%0d exp 11/0/3/0", score1, score2, state, winner); end
    checks++; if ({bx, by} !== {11'd792, 11'd494}) begin errors++; $display("FAIL over_ball bx=%0d by=%0d exp 792/494", bx, by); end
    p1_up = 1'b1;
    ticks(3);
    p1_up = 1'b0;
    checks++; if ({state, p1_y, bx, by} !== {2'd3, 11'd268, 11'd792, 11'd494}) begin errors++; $display("FAIL over_frozen st=%0d p1=%0d bx=%0d by=%0d exp 3/268/792/494", state, p1_y, bx, by); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({score1, score2, state, bx, by} !== {5'd0, 5'd0, 2'd1, 11'd396, 11'd296}) begin errors++; $display("FAIL restart s1=%0d s2=%0d st=%0d bx=%0d by=%0d exp 0/0/1/396/296", score1, score2, state, bx, by); end
    ticks(61);
    checks++; if ({bx, by} !== {11'd398, 11'd294}) begin errors++; $display("FAIL restart_dir bx=%0d by=%0d exp 398/294", bx, by); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    p1_up = 1'b1;
    ticks(62);
    checks++; if ({p1_y, bx, by, state} !== {11'd20, 11'd400, 11'd300, 2'd2}) begin errors++; $display("FAIL pre_reset p1=%0d bx=%0d by=%0d st=%0d exp 20/400/300/2", p1_y, bx, by, state); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({p1_y, bx, by, state} !== {11'd268, 11'd396, 11'd296, 2'd0}) begin errors++; $display("FAIL async_reset p1=%0d bx=%0d by=%0d st=%0d exp 268/396/296/0", p1_y, bx, by, state); end
    @(negedge clk);
    rst = 1'b0;
    p1_up = 1'b0;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_paddle();
    test_wall();
    test_bat_return(1'b0);
    test_bat_return(1'b1);
    test_win();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
